// File: rtl/mac_vec_seq_pkg.sv
// Shared types and constants for the MAC operand sequencer.
package mac_vec_seq_pkg;

  localparam int unsigned OP_W        = 8;
  localparam int unsigned ACC_W       = 16;
  localparam int unsigned MAC_LAT_DEF = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    HOLD  = 3'd4
  } state_t;

endpackage

// File: rtl/mac_vec_seq.sv
// Operand sequencer for the 8x8 MAC: clears the accumulator, streams operand
// pairs (zeros on bubbles), waits out the MAC latency and returns the sum.
module mac_vec_seq
  import mac_vec_seq_pkg::*;
#(
  parameter int unsigned LEN_W   = 8,
  parameter int unsigned MAC_LAT = MAC_LAT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [OP_W-1:0]  a_x,
  input  logic [OP_W-1:0]  a_y,
  output logic [OP_W-1:0]  mac_x,
  output logic [OP_W-1:0]  mac_y,
  output logic             mac_clr,
  input  logic [ACC_W-1:0] mac_acc,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_data,
  output logic             busy
);

  localparam int unsigned DCNT_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  state_t              state;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    cnt;
  logic [DCNT_W-1:0]   dcnt;

  // a_ready is a registered copy of (state==FEED), so gating on it is
  // equivalent to gating on the state itself.
  always_comb begin
    mac_x   = '0;
    mac_y   = '0;
    mac_clr = reset | (state == CLEAR);
    if (a_ready && a_valid) begin
      mac_x = a_x;
      mac_y = a_y;
    end
  end

  // Sequencer FSM with registered handshake and status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      len_q     <= '0;
      cnt       <= '0;
      dcnt      <= '0;
      res_data  <= '0;
      res_valid <= 1'b0;
      a_ready   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (len != '0) begin
              len_q <= len;
              cnt   <= '0;
              state <= CLEAR;
            end else begin
              res_data  <= '0;
              res_valid <= 1'b1;
              state     <= HOLD;
            end
          end
        end
        CLEAR: begin
          a_ready <= 1'b1;
          state   <= FEED;
        end
        FEED: begin
          if (a_valid) begin
            cnt <= cnt + LEN_W'(1);
            if (cnt == len_q - LEN_W'(1)) begin
              a_ready <= 1'b0;
              dcnt    <= '0;
              state   <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (dcnt == DCNT_W'(MAC_LAT - 1)) begin
            res_data  <= mac_acc;
            res_valid <= 1'b1;
            state     <= HOLD;
          end else begin
            dcnt <= dcnt + DCNT_W'(1);
          end
        end
        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          res_valid <= 1'b0;
          a_ready   <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_vec_seq.sv
// Directed bench for mac_vec_seq with a behavioural 8x8 MAC beside it.
module tb_mac_vec_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  len;
  logic        a_valid;
  logic        a_ready;
  logic [7:0]  a_x, a_y;
  logic [7:0]  mac_x, mac_y;
  logic        mac_clr;
  logic [15:0] mac_acc;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic        busy;

  int checks = 0;
  int errors = 0;

  mac_vec_seq #(.LEN_W(8), .MAC_LAT(2)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .a_valid(a_valid), .a_ready(a_ready), .a_x(a_x), .a_y(a_y),
    .mac_x(mac_x), .mac_y(mac_y), .mac_clr(mac_clr), .mac_acc(mac_acc),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // MAC: input registers, then accumulator; mac_clr is a synchronous clear.
  logic [7:0] xr, yr;
  always_ff @(posedge clk) begin
    if (mac_clr) begin
      xr      <= '0;
      yr      <= '0;
      mac_acc <= '0;
    end else begin
      xr      <= mac_x;
      yr      <= mac_y;
      mac_acc <= mac_acc + {8'b0, xr} * {8'b0, yr};
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  // Pulse start with the given length; returns positioned in the first FEED cycle.
  task automatic start_vec(input logic [7:0] l);
    start = 1'b1;
    len   = l;
    cyc();
    start = 1'b0;
    len   = 8'd77;
    chk("clear_mac_clr", 32'(mac_clr), 1);
    chk("clear_busy", 32'(busy), 1);
    chk("clear_a_ready", 32'(a_ready), 0);
    cyc();
  endtask

  task automatic do_pair(input logic [7:0] x, input logic [7:0] y);
    a_valid = 1'b1;
    a_x     = x;
    a_y     = y;
    #1;
    chk("feed_a_ready", 32'(a_ready), 1);
    chk("feed_mac_x", 32'(mac_x), 32'(x));
    chk("feed_mac_y", 32'(mac_y), 32'(y));
    chk("feed_busy", 32'(busy), 1);
    cyc();
    a_valid = 1'b0;
  endtask

  task automatic bubble();
    a_valid = 1'b0;
    a_x     = 8'd99;
    a_y     = 8'd98;
    #1;
    chk("bubble_mac_x", 32'(mac_x), 0);
    chk("bubble_mac_y", 32'(mac_y), 0);
    chk("bubble_a_ready", 32'(a_ready), 1);
    cyc();
  endtask

  // Called in the first cycle after the final acceptance.
  task automatic expect_result(input string tag, input logic [15:0] exp);
    chk({tag, "_drain1_valid"}, 32'(res_valid), 0);
    chk({tag, "_drain1_ready"}, 32'(a_ready), 0);
    cyc();
    chk({tag, "_drain2_valid"}, 32'(res_valid), 0);
    chk({tag, "_drain2_busy"}, 32'(busy), 1);
    cyc();
    chk({tag, "_hold_valid"}, 32'(res_valid), 1);
    chk({tag, "_hold_data"}, 32'(res_data), 32'(exp));
  endtask

  task automatic take_result(input string tag);
    res_ready = 1'b1;
    cyc();
    res_ready = 1'b0;
    chk({tag, "_idle_valid"}, 32'(res_valid), 0);
    chk({tag, "_idle_busy"}, 32'(busy), 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; len = '0; a_valid = 1'b0;
    a_x = '0; a_y = '0; res_ready = 1'b0;
    cyc();
    cyc();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_a_ready", 32'(a_ready), 0);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_res_data", 32'(res_data), 0);
    chk("rst_mac_clr", 32'(mac_clr), 1);
    reset = 1'b0;
    #1;
    chk("idle_mac_clr", 32'(mac_clr), 0);
    cyc();

    // 1: back-to-back pairs, 2*3+4*5+6*7 = 68
    start_vec(8'd3);
    do_pair(8'd2, 8'd3);
    do_pair(8'd4, 8'd5);
    do_pair(8'd6, 8'd7);
    expect_result("t1", 16'd68);
    take_result("t1");

    // 2: two bubbles between pairs
    start_vec(8'd3);
    do_pair(8'd2, 8'd3);
    bubble(); bubble();
    do_pair(8'd4, 8'd5);
    bubble(); bubble();
    do_pair(8'd6, 8'd7);
    expect_result("t2", 16'd68);

    // 3: back-pressure with start pulsed during HOLD
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      len   = 8'd5;
      a_valid = 1'b1;
      a_x = 8'd11;
      #1;
      chk("t3_hold_data", 32'(res_data), 68);
      chk("t3_hold_valid", 32'(res_valid), 1);
      chk("t3_hold_a_ready", 32'(a_ready), 0);
      chk("t3_hold_mac_x", 32'(mac_x), 0);
      cyc();
    end
    start = 1'b0;
    a_valid = 1'b0;
    take_result("t3");
    cyc();
    chk("t3_still_idle", 32'(busy), 0);

    // 4: zero-length vector goes straight to HOLD with result 0
    start = 1'b1;
    len   = 8'd0;
    #1;
    chk("t4_idle_mac_clr", 32'(mac_clr), 0);
    cyc();
    start = 1'b0;
    chk("t4_hold_valid", 32'(res_valid), 1);
    chk("t4_hold_data", 32'(res_data), 0);
    chk("t4_mac_clr", 32'(mac_clr), 0);
    chk("t4_a_ready", 32'(a_ready), 0);
    take_result("t4");

    // 5: wrap, 2*255*255 = 130050 -> 64514, then 1*1 = 1
    start_vec(8'd2);
    do_pair(8'd255, 8'd255);
    do_pair(8'd255, 8'd255);
    expect_result("t5a", 16'd64514);
    take_result("t5a");
    start_vec(8'd1);
    do_pair(8'd1, 8'd1);
    expect_result("t5b", 16'd1);
    take_result("t5b");

    // 6: reset mid-FEED after 2 of 4 pairs
    start_vec(8'd4);
    do_pair(8'd9, 8'd9);
    do_pair(8'd8, 8'd8);
    a_valid = 1'b1;
    a_x = 8'd7;
    a_y = 8'd7;
    reset = 1'b1;
    #1;
    chk("t6_busy", 32'(busy), 0);
    chk("t6_a_ready", 32'(a_ready), 0);
    chk("t6_mac_x", 32'(mac_x), 0);
    chk("t6_mac_y", 32'(mac_y), 0);
    chk("t6_res_data", 32'(res_data), 0);
    chk("t6_res_valid", 32'(res_valid), 0);
    chk("t6_mac_clr", 32'(mac_clr), 1);
    cyc();
    a_valid = 1'b0;
    reset = 1'b0;
    cyc();
    start_vec(8'd1);
    do_pair(8'd3, 8'd3);
    expect_result("t6", 16'd9);

    // reset while holding a result drops res_valid without a clock edge
    #2;
    reset = 1'b1;
    #1;
    chk("t6_hold_rst_valid", 32'(res_valid), 0);
    chk("t6_hold_rst_data", 32'(res_data), 0);
    cyc();
    reset = 1'b0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
